// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the single register-file write port between the
// execute-stage result (requester 0) and the memory/load result (requester 1).
// Round-robin grant with valid/ready handshakes, one registered output stage
// driving destWB/resultWB/writeBackEn, and read-after-write hazard flags for
// the two decode read ports.
// Optional build macro WB_ARB_STATS_EN adds saturating conflict_cnt/stall_cnt.
module wb_port_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_dest,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_dest,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              wb_stall,
    output logic [ADDR_W-1:0] destWB,
    output logic [DATA_W-1:0] resultWB,
    output logic              writeBackEn,
    input  logic [ADDR_W-1:0] src1,
    input  logic [ADDR_W-1:0] src2,
    output logic              hazard1,
    output logic              hazard2
`ifdef WB_ARB_STATS_EN
    ,
    output logic [15:0]       conflict_cnt,
    output logic [15:0]       stall_cnt
`endif
);

    // last_grant = 1 after reset so requester 0 wins the first contention
    logic              last_grant_q, last_grant_d;
    logic              wb_en_q, wb_en_d;
    logic [ADDR_W-1:0] dest_q, dest_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              grant0, grant1;

    // Hazard when a read index matches a pending request or the write in flight
    function automatic logic src_match(
        input logic [ADDR_W-1:0] src,
        input logic              v0, input logic [ADDR_W-1:0] d0,
        input logic              v1, input logic [ADDR_W-1:0] d1,
        input logic              v2, input logic [ADDR_W-1:0] d2
    );
        return (v0 && (d0 == src)) || (v1 && (d1 == src)) || (v2 && (d2 == src));
    endfunction

    // Round-robin grant; a grant always coincides with valid, so grant == transfer
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst && !wb_stall) begin
            if (req0_valid && req1_valid) begin
                if (last_grant_q) grant0 = 1'b1;
                else              grant1 = 1'b1;
            end else if (req0_valid) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Next state of the output stage and the round-robin pointer
    always_comb begin
        last_grant_d = last_grant_q;
        wb_en_d      = 1'b0;
        dest_d       = dest_q;
        data_d       = data_q;
        if (grant0) begin
            last_grant_d = 1'b0;
            wb_en_d      = 1'b1;
            dest_d       = req0_dest;
            data_d       = req0_data;
        end else if (grant1) begin
            last_grant_d = 1'b1;
            wb_en_d      = 1'b1;
            dest_d       = req1_dest;
            data_d       = req1_data;
        end
    end

    // Output stage registers, cleared immediately by the asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            wb_en_q      <= 1'b0;
            dest_q       <= '0;
            data_q       <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            wb_en_q      <= wb_en_d;
            dest_q       <= dest_d;
            data_q       <= data_d;
        end
    end

    assign writeBackEn = wb_en_q;
    assign destWB      = dest_q;
    assign resultWB    = data_q;

    // Read-after-write hazard flags for the decode read ports
    always_comb begin
        hazard1 = src_match(src1, req0_valid, req0_dest, req1_valid, req1_dest,
                            wb_en_q, dest_q);
        hazard2 = src_match(src2, req0_valid, req0_dest, req1_valid, req1_dest,
                            wb_en_q, dest_q);
    end

`ifdef WB_ARB_STATS_EN
    logic [15:0] conflict_cnt_q, conflict_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating counters: contention cycles and stalled-with-request cycles
    always_comb begin
        conflict_cnt_d = conflict_cnt_q;
        stall_cnt_d    = stall_cnt_q;
        if (req0_valid && req1_valid && !wb_stall && (conflict_cnt_q != 16'hFFFF))
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        if (wb_stall && (req0_valid || req1_valid) && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    // Counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt_q <= '0;
            stall_cnt_q    <= '0;
        end else begin
            conflict_cnt_q <= conflict_cnt_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

    assign conflict_cnt = conflict_cnt_q;
    assign stall_cnt    = stall_cnt_q;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int NV = 22;

    logic              clk;
    logic              rst;
    logic              req0_valid, req1_valid, wb_stall;
    logic [ADDR_W-1:0] req0_dest, req1_dest, src1, src2;
    logic [DATA_W-1:0] req0_data, req1_data;
    logic              req0_ready, req1_ready, writeBackEn, hazard1, hazard2;
    logic [ADDR_W-1:0] destWB;
    logic [DATA_W-1:0] resultWB;
`ifdef WB_ARB_STATS_EN
    logic [15:0]       conflict_cnt, stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    wb_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_dest(req0_dest), .req0_data(req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_dest(req1_dest), .req1_data(req1_data),
        .req1_ready(req1_ready),
        .wb_stall(wb_stall),
        .destWB(destWB), .resultWB(resultWB), .writeBackEn(writeBackEn),
        .src1(src1), .src2(src2), .hazard1(hazard1), .hazard2(hazard2)
`ifdef WB_ARB_STATS_EN
        ,
        .conflict_cnt(conflict_cnt), .stall_cnt(stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        do_rst;
        logic        v0;
        logic [3:0]  d0;
        logic [31:0] x0;
        logic        v1;
        logic [3:0]  d1;
        logic [31:0] x1;
        logic        stall;
        logic [3:0]  s1;
        logic [3:0]  s2;
        logic        e_r0;
        logic        e_r1;
        logic        e_h1;
        logic        e_h2;
        logic        e_en;
        logic [3:0]  e_dest;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic setv(input int i, input logic r,
                        input logic v0, input logic [3:0] d0, input logic [31:0] x0,
                        input logic v1, input logic [3:0] d1, input logic [31:0] x1,
                        input logic st, input logic [3:0] s1, input logic [3:0] s2,
                        input logic r0, input logic r1, input logic h1, input logic h2,
                        input logic en, input logic [3:0] ed, input logic [31:0] ex);
        vecs[i] = '{r, v0, d0, x0, v1, d1, x1, st, s1, s2, r0, r1, h1, h2, en, ed, ex};
    endtask

    task automatic drive(input vec_t v);
        req0_valid = v.v0; req0_dest = v.d0; req0_data = v.x0;
        req1_valid = v.v1; req1_dest = v.d1; req1_data = v.x1;
        wb_stall = v.stall; src1 = v.s1; src2 = v.s2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        // rst v0 d0 x0            v1 d1 x1       st s1 s2  r0 r1 h1 h2 en dest data
        setv( 0, 1, 1, 3, 32'hA5A5_0001, 0, 0, 0,     0, 3, 0,  1, 0, 1, 0, 1, 3, 32'hA5A5_0001);
        setv( 1, 0, 0, 0, 0,             0, 0, 0,     0, 3, 0,  0, 0, 1, 0, 0, 3, 32'hA5A5_0001);
        setv( 2, 0, 0, 0, 0,             0, 0, 0,     0, 3, 0,  0, 0, 0, 0, 0, 3, 32'hA5A5_0001);
        setv( 3, 1, 1, 1, 32'h11,        1, 2, 32'h22, 0, 1, 2, 1, 0, 1, 1, 1, 1, 32'h11);
        setv( 4, 0, 0, 0, 0,             1, 2, 32'h22, 0, 1, 2, 0, 1, 1, 1, 1, 2, 32'h22);
        setv( 5, 0, 0, 0, 0,             0, 0, 0,     0, 2, 1,  0, 0, 1, 0, 0, 2, 32'h22);
        setv( 6, 0, 1, 4, 32'h100,       1, 6, 32'h200, 0, 0, 0, 1, 0, 0, 0, 1, 4, 32'h100);
        setv( 7, 0, 1, 4, 32'h101,       1, 6, 32'h200, 0, 0, 0, 0, 1, 0, 0, 1, 6, 32'h200);
        setv( 8, 0, 1, 4, 32'h101,       1, 6, 32'h201, 0, 0, 0, 1, 0, 0, 0, 1, 4, 32'h101);
        setv( 9, 0, 1, 4, 32'h102,       1, 6, 32'h201, 0, 0, 0, 0, 1, 0, 0, 1, 6, 32'h201);
        setv(10, 0, 1, 4, 32'h102,       1, 6, 32'h202, 0, 0, 0, 1, 0, 0, 0, 1, 4, 32'h102);
        setv(11, 0, 1, 4, 32'h103,       1, 6, 32'h202, 0, 0, 0, 0, 1, 0, 0, 1, 6, 32'h202);
        setv(12, 0, 1, 5, 32'h50,        1, 5, 32'h51, 0, 5, 6, 1, 0, 1, 1, 1, 5, 32'h50);
        setv(13, 0, 0, 0, 0,             1, 5, 32'h51, 0, 5, 6, 0, 1, 1, 0, 1, 5, 32'h51);
        setv(14, 0, 0, 0, 0,             0, 0, 0,     0, 5, 6,  0, 0, 1, 0, 0, 5, 32'h51);
        setv(15, 0, 0, 0, 0,             1, 7, 32'h77, 1, 7, 5, 0, 0, 1, 0, 0, 5, 32'h51);
        setv(16, 0, 0, 0, 0,             1, 7, 32'h77, 1, 7, 5, 0, 0, 1, 0, 0, 5, 32'h51);
        setv(17, 0, 0, 0, 0,             1, 7, 32'h77, 1, 7, 5, 0, 0, 1, 0, 0, 5, 32'h51);
        setv(18, 0, 0, 0, 0,             1, 7, 32'h77, 0, 7, 5, 0, 1, 1, 0, 1, 7, 32'h77);
        setv(19, 0, 0, 0, 0,             0, 0, 0,     0, 7, 5,  0, 0, 1, 0, 0, 7, 32'h77);
        setv(20, 0, 1, 9, 32'h99,        0, 0, 0,     0, 9, 0,  1, 0, 1, 0, 1, 9, 32'h99);
        setv(21, 0, 1, 10, 32'hAA,       0, 0, 0,     1, 9, 0,  0, 0, 1, 0, 0, 9, 32'h99);

        rst = 1'b1;
        drive('{default: '0});
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_en",   {31'd0, writeBackEn}, 32'd0);
        chk("reset_dest", {28'd0, destWB}, 32'd0);
        chk("reset_data", resultWB, 32'd0);

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].do_rst) do_reset();
            drive(vecs[i]);
            @(negedge clk);
            chk($sformatf("v%0d_ready0", i), {31'd0, req0_ready}, {31'd0, vecs[i].e_r0});
            chk($sformatf("v%0d_ready1", i), {31'd0, req1_ready}, {31'd0, vecs[i].e_r1});
            chk($sformatf("v%0d_hazard1", i), {31'd0, hazard1}, {31'd0, vecs[i].e_h1});
            chk($sformatf("v%0d_hazard2", i), {31'd0, hazard2}, {31'd0, vecs[i].e_h2});
            @(posedge clk); #1;
            chk($sformatf("v%0d_wben", i), {31'd0, writeBackEn}, {31'd0, vecs[i].e_en});
            chk($sformatf("v%0d_dest", i), {28'd0, destWB}, {28'd0, vecs[i].e_dest});
            chk($sformatf("v%0d_data", i), resultWB, vecs[i].e_data);
        end

`ifdef WB_ARB_STATS_EN
        chk("conflict_cnt", {16'd0, conflict_cnt}, 32'd8);
        chk("stall_cnt",    {16'd0, stall_cnt},    32'd4);
`endif

        // Asynchronous reset while a write sits in the output stage
        drive('{default: '0});
        req0_valid = 1'b1; req0_dest = 4'd3; req0_data = 32'h33;
        @(posedge clk); #1;
        chk("async_pre_wben", {31'd0, writeBackEn}, 32'd1);
        req0_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("async_wben", {31'd0, writeBackEn}, 32'd0);
        chk("async_dest", {28'd0, destWB}, 32'd0);
        chk("async_data", resultWB, 32'd0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_dest = 4'd1; req1_dest = 4'd2;
        req0_data = 32'hC0; req1_data = 32'hC1;
        #1;
        chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
        chk("rst_ready1", {31'd0, req1_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_ready0", {31'd0, req0_ready}, 32'd1);
        chk("post_rst_ready1", {31'd0, req1_ready}, 32'd0);
        @(posedge clk); #1;
        chk("post_rst_wben", {31'd0, writeBackEn}, 32'd1);
        chk("post_rst_dest", {28'd0, destWB}, 32'd1);
        chk("post_rst_data", resultWB, 32'hC0);
        req0_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_second", {31'd0, req1_ready}, 32'd1);
        @(posedge clk); #1;
        chk("post_rst_dest2", {28'd0, destWB}, 32'd2);
        req1_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
